// File: rtl/qupls_decode_rt_group_pkg.sv
// QuplsPkg: shared types and decode helpers for the grouped Rt decoder.
//   aregno_t          architectural register number (0..63)
//   operating_mode_t  processor operating mode (3 selects IPL banking)
//   ex_instruction_t  extracted instruction fields seen by the decoders
//   fnRtRaw()         unbanked target register of one instruction
package QuplsPkg;

  typedef logic [5:0] aregno_t;
  typedef logic [6:0] opcode_t;
  typedef logic [5:0] func_t;

  typedef enum logic [1:0] {
    OM_APP    = 2'd0,
    OM_SUPER  = 2'd1,
    OM_HYPER  = 2'd2,
    OM_SECURE = 2'd3
  } operating_mode_t;

  typedef struct packed {
    opcode_t opcode;
    aregno_t aRt;
    aregno_t aRa;
    aregno_t aRb;
    logic    lk;
    func_t   func;
  } ex_instruction_t;

  // Opcodes
  localparam opcode_t OP_R2    = 7'd2;
  localparam opcode_t OP_FLT3  = 7'd3;
  localparam opcode_t OP_BSR   = 7'd4;
  localparam opcode_t OP_JSR   = 7'd5;
  localparam opcode_t OP_ADDI  = 7'd8;
  localparam opcode_t OP_SUBFI = 7'd9;
  localparam opcode_t OP_CMPI  = 7'd10;
  localparam opcode_t OP_MULI  = 7'd11;
  localparam opcode_t OP_DIVI  = 7'd12;
  localparam opcode_t OP_SLTI  = 7'd13;
  localparam opcode_t OP_MULUI = 7'd14;
  localparam opcode_t OP_DIVUI = 7'd15;
  localparam opcode_t OP_ANDI  = 7'd16;
  localparam opcode_t OP_ORI   = 7'd17;
  localparam opcode_t OP_EORI  = 7'd18;
  localparam opcode_t OP_ADDSI = 7'd20;
  localparam opcode_t OP_ANDSI = 7'd21;
  localparam opcode_t OP_ORSI  = 7'd22;
  localparam opcode_t OP_EORSI = 7'd23;
  localparam opcode_t OP_AIPSI = 7'd24;
  localparam opcode_t OP_SHIFT = 7'd26;
  localparam opcode_t OP_CSR   = 7'd27;
  localparam opcode_t OP_MOV   = 7'd28;
  localparam opcode_t OP_MCB   = 7'd32;
  localparam opcode_t OP_RTD   = 7'd33;
  localparam opcode_t OP_DBRA  = 7'd34;
  localparam opcode_t OP_BCC   = 7'd36;
  // Loads occupy 64..71 (opcode[6:3] == 4'b1000); stores start at 72.
  localparam opcode_t OP_LDB   = 7'd64;
  localparam opcode_t OP_LDO   = 7'd70;
  localparam opcode_t OP_STO   = 7'd72;
  localparam opcode_t OP_NOP   = 7'd127;

  // R2 function codes that write Rt
  localparam func_t FN_ADD  = 6'd0;
  localparam func_t FN_SUB  = 6'd1;
  localparam func_t FN_CMP  = 6'd2;
  localparam func_t FN_MUL  = 6'd3;
  localparam func_t FN_DIV  = 6'd4;
  localparam func_t FN_AND  = 6'd5;
  localparam func_t FN_OR   = 6'd6;
  localparam func_t FN_EOR  = 6'd7;
  localparam func_t FN_SLT  = 6'd8;
  localparam func_t FN_SEQ  = 6'd9;
  localparam func_t FN_SNE  = 6'd10;
  localparam func_t FN_ZSEQ = 6'd12;
  localparam func_t FN_ZSNE = 6'd13;

  // Default fixed-target registers
  localparam aregno_t SP_REG_DEF   = 6'd31;
  localparam aregno_t LK_REG_DEF   = 6'd59;
  localparam aregno_t DBRA_REG_DEF = 6'd55;

  function automatic aregno_t fnRtRaw(input ex_instruction_t ins,
                                      input aregno_t sp_reg   = SP_REG_DEF,
                                      input aregno_t lk_reg   = LK_REG_DEF,
                                      input aregno_t dbra_reg = DBRA_REG_DEF);
    aregno_t rt;
    rt = '0;
    case (ins.opcode)
      OP_R2:
        case (ins.func)
          FN_ADD, FN_SUB, FN_CMP, FN_MUL, FN_DIV, FN_AND, FN_OR, FN_EOR,
          FN_SLT, FN_SEQ, FN_SNE, FN_ZSEQ, FN_ZSNE: rt = ins.aRt;
          default: rt = '0;
        endcase
      OP_FLT3, OP_BSR, OP_JSR, OP_ADDI, OP_SUBFI, OP_CMPI, OP_MULI, OP_DIVI,
      OP_SLTI, OP_MULUI, OP_DIVUI, OP_ANDI, OP_ORI, OP_EORI, OP_ADDSI,
      OP_ANDSI, OP_ORSI, OP_EORSI, OP_AIPSI, OP_SHIFT, OP_CSR, OP_MOV:
        rt = ins.aRt;
      OP_MCB:  rt = ins.lk ? lk_reg : '0;
      OP_RTD:  rt = sp_reg;
      OP_DBRA: rt = dbra_reg;
      default: rt = (ins.opcode[6:3] == 4'b1000) ? ins.aRt : '0;
    endcase
    return rt;
  endfunction

endpackage

// File: rtl/qupls_decode_rt_group_lane.sv
// qupls_decode_rt_lane: combinational target decode for one lane.
//   instr  instruction of this lane
//   valid  lane valid; an invalid lane decodes to register 0
//   om     operating mode sampled with the group
//   ipl    interrupt level sampled with the group
//   rt     decoded target after stack-pointer banking
module qupls_decode_rt_lane
  import QuplsPkg::*;
#(
  parameter int SP_REG   = 31,
  parameter int IPL_BASE = 32,
  parameter int OM_BASE  = 40,
  parameter int LK_REG   = 59,
  parameter int DBRA_REG = 55
) (
  input  ex_instruction_t instr,
  input  logic            valid,
  input  operating_mode_t om,
  input  logic [2:0]      ipl,
  output aregno_t         rt
);

  aregno_t raw;

  always_comb begin
    raw = valid ? fnRtRaw(instr, aregno_t'(SP_REG), aregno_t'(LK_REG),
                          aregno_t'(DBRA_REG)) : '0;
    rt  = raw;
    // The stack pointer is replicated per IPL in secure mode, per mode otherwise.
    if (raw == aregno_t'(SP_REG)) begin
      if (om == OM_SECURE)
        rt = aregno_t'(IPL_BASE) | aregno_t'(ipl);
      else
        rt = aregno_t'(OM_BASE) | aregno_t'(om);
    end
  end

endmodule

// File: rtl/qupls_decode_rt_group.sv
// qupls_decode_rt_group: registered multi-lane Rt decoder.
// Decodes and banks Rt for every lane of a fetch group, flags lanes whose
// target is rewritten by a younger lane of the same group, and queues the
// result in a 2-entry FIFO between extract and rename.
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop every buffered group
//   in_valid/in_ready   group handshake (in_ready from registered count)
//   instr, lane_v       lane instructions (lane 0 oldest) and lane valids
//   om, ipl             mode / interrupt level sampled with the group
//   out_valid/out_ready head-group handshake
//   Rt, Rtz, Rt_ovr     banked target, zero flag, WAW-override flag per lane
//   out_lane_v          lane valids carried with the group
module qupls_decode_rt_group
  import QuplsPkg::*;
#(
  parameter int LANES    = 4,
  parameter int SP_REG   = 31,
  parameter int IPL_BASE = 32,
  parameter int OM_BASE  = 40,
  parameter int LK_REG   = 59,
  parameter int DBRA_REG = 55
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  ex_instruction_t [LANES-1:0] instr,
  input  logic [LANES-1:0]            lane_v,
  input  operating_mode_t             om,
  input  logic [2:0]                  ipl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output aregno_t [LANES-1:0]         Rt,
  output logic [LANES-1:0]            Rtz,
  output logic [LANES-1:0]            Rt_ovr,
  output logic [LANES-1:0]            out_lane_v
);

  aregno_t [LANES-1:0] rt_dec;
  logic [LANES-1:0]    rtz_dec;
  logic [LANES-1:0]    ovr_dec;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      qupls_decode_rt_lane #(
        .SP_REG  (SP_REG),
        .IPL_BASE(IPL_BASE),
        .OM_BASE (OM_BASE),
        .LK_REG  (LK_REG),
        .DBRA_REG(DBRA_REG)
      ) u_lane (
        .instr(instr[gi]),
        .valid(lane_v[gi]),
        .om   (om),
        .ipl  (ipl),
        .rt   (rt_dec[gi])
      );
      assign rtz_dec[gi] = (rt_dec[gi] == '0);
    end
  endgenerate

  // Override matrix on post-banking targets. Invalid lanes decode to 0, so a
  // nonzero rt_dec[i] already implies lane i is valid.
  always_comb begin
    ovr_dec = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (lane_v[j] && (rt_dec[j] == rt_dec[i]) && (rt_dec[i] != '0))
          ovr_dec[i] = 1'b1;
      end
    end
  end

  // Two-entry FIFO
  aregno_t [LANES-1:0] rt_mem_q  [2];
  logic [LANES-1:0]    rtz_mem_q [2];
  logic [LANES-1:0]    ovr_mem_q [2];
  logic [LANES-1:0]    lv_mem_q  [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                push, pop;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = (count_q != 2'd2);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        rt_mem_q[k]  <= '0;
        rtz_mem_q[k] <= '1;
        ovr_mem_q[k] <= '0;
        lv_mem_q[k]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        rt_mem_q[wr_ptr_q]  <= rt_dec;
        rtz_mem_q[wr_ptr_q] <= rtz_dec;
        ovr_mem_q[wr_ptr_q] <= ovr_dec;
        lv_mem_q[wr_ptr_q]  <= lane_v;
      end
    end
  end

  // An empty buffer presents the idle pattern rather than stale storage.
  assign Rt         = out_valid ? rt_mem_q[rd_ptr_q]  : '0;
  assign Rtz        = out_valid ? rtz_mem_q[rd_ptr_q] : '1;
  assign Rt_ovr     = out_valid ? ovr_mem_q[rd_ptr_q] : '0;
  assign out_lane_v = out_valid ? lv_mem_q[rd_ptr_q]  : '0;

endmodule

// File: doc/qupls_decode_rt_group.md
Name: qupls_decode_rt_group

Overview:
- Multi-lane, registered successor to the single-instruction target-register decoder.
- Decodes the architectural target register (Rt) for up to LANES instructions per fetch group.
- Applies operating-mode and IPL banking of the stack-pointer register, and flags intra-group write-after-write overrides.
- Sits between the instruction extract stage and rename, with a 2-entry skid buffer on a valid/ready handshake.

Parameters:
- LANES, 4, instructions per group (1..8).
- SP_REG, 31, architectural register that is banked.
- IPL_BASE, 32, bank base used when om==3; result is IPL_BASE|ipl.
- OM_BASE, 40, bank base used when om!=3; result is OM_BASE|om.
- LK_REG, 59, link register written by OP_MCB with lk set.
- DBRA_REG, 55, implicit target of OP_DBRA.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous discard of all buffered groups.
- in_valid, input, 1, group present on the inputs.
- in_ready, output, 1, block can accept a group; registered.
- instr, input, LANES x ex_instruction_t, group instructions; lane 0 is oldest.
- lane_v, input, LANES, per-lane instruction valid.
- om, input, operating_mode_t, operating mode sampled with the group.
- ipl, input, 3, interrupt level sampled with the group.
- out_valid, output, 1, head group valid.
- out_ready, input, 1, consumer accepts the head group.
- Rt, output, LANES x aregno_t, decoded and banked target per lane.
- Rtz, output, LANES, Rt==0 per lane.
- Rt_ovr, output, LANES, a younger valid lane in the same group writes the same nonzero Rt.
- out_lane_v, output, LANES, lane_v carried with the group.

Behaviour:
- Reset (asynchronous, rst high): buffer count=0, out_valid=0, in_ready=1, Rt=0, Rtz=all 1, Rt_ovr=0, out_lane_v=0.
- Per-lane raw decode:
  - R2 arithmetic/logic/set/zero-set funcs, FLT3, BSR, JSR, ADDI/SUBFI/CMPI, MULI/DIVI, SLTI/MULUI/DIVUI/ANDI/ORI/EORI, ADDSI/ANDSI/ORSI/EORSI/AIPSI, SHIFT, CSR, MOV and all loads: Rt = aRt.
  - R2 with any other func: Rt = 0.
  - OP_MCB: LK_REG if lk set, else 0.
  - OP_RTD: SP_REG.
  - OP_DBRA: DBRA_REG.
  - All other opcodes: 0.
  - Invalid lane (lane_v=0): 0.
- Banking: if raw==SP_REG then Rt = (om==3) ? IPL_BASE|ipl : OM_BASE|om. The om and ipl values are those sampled at accept; a later om/ipl change never alters buffered entries.
- Override: Rt_ovr[i]=1 iff there exists j>i with lane_v[j], Rt[j]==Rt[i], Rt[i]!=0. The comparison uses post-banking values. Rt_ovr for the youngest lane is always 0.
- Rtz = ~|Rt per lane, computed before the buffer and stored with the entry.
- Buffer: 2-entry FIFO of {Rt, Rtz, Rt_ovr, lane_v}.
  - Push on in_valid & in_ready.
  - Pop on out_valid & out_ready.
  - Latency: accept at edge N gives out_valid=1 after edge N, visible in cycle N+1 (1 cycle).
  - in_ready = (count<2) from registered count; there is no combinational path from out_ready to in_ready.
  - At count==2 with a pop, in_ready rises the following cycle.
  - Simultaneous push and pop at count==1: count stays 1 and the new group becomes head next cycle.
  - Outputs show the head entry. When count==0, Rt/Rt_ovr/out_lane_v are held at 0 and Rtz at all 1.
- Flush: next count=0 and out_valid=0. A push or pop in the flush cycle is discarded. in_ready=1 the following cycle.
- rst asserted mid-transfer: buffer is cleared immediately and contents are lost; no partial group is ever emitted.

Decomposition:
- QuplsPkg: ex_instruction_t, aregno_t, operating_mode_t, opcode/func constants, and a shared function fnRtRaw(ex_instruction_t) returning the unbanked Rt. Bank bases stay module parameters.
- Sub-module qupls_decode_rt_lane: combinational raw decode plus banking for one lane, with inputs instr, valid, om, ipl and output aregno_t.
- Top level holds the override comparator matrix and the skid FIFO.

Test Plan:
- Reset, then one group with lanes ADDI aRt=5, RTD, MCB lk=1, DBRA, om=1 -> next cycle out_valid=1, Rt={5,41,59,55}, Rtz=0000, Rt_ovr=0000.
- RTD in lane 0, om=3, ipl=6 -> Rt[0]=38. Change om to 0 before pop -> head still shows 38.
- Lanes MOV aRt=7, ADDI aRt=7, R2 unsupported func, LDO aRt=7 -> Rt={7,7,0,7}, Rt_ovr={1,1,0,0}, Rtz={0,0,1,0}.
- out_ready=0, push 3 consecutive groups -> first two accepted, in_ready=0 after the second push. Release out_ready -> groups emerge in order and the third is accepted one cycle after the first pop.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count=0, in_ready=1, and the offered group is not emitted.
- Assert rst asynchronously between clock edges while out_valid=1 -> out_valid drops immediately, Rtz=all 1, and no output appears after release until a new push.
